// File: rtl/fp_sched_pkg.sv
// rtl/fp_sched_pkg.sv - shared types and constants for the FP32 add scheduler
// Purpose: FP32 field positions, the fp32_t word type and the tag width helper.
package fp_sched_pkg;

    localparam int FP_W    = 32;
    localparam int FP_SIGN = 31;

    typedef logic [FP_W-1:0] fp32_t;

    // Tag width for n requesters; a single requester still gets a 1-bit tag.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fp_add_sched_arb.sv
// rtl/fp_add_sched_arb.sv - round-robin arbiter for the FP32 add scheduler
// Purpose: pick the first requester at or above ptr (mod N).
// Ports: req (N requests), ptr (search start), en (grant enable),
//        gnt (one-hot grant, zero when en is low), idx (winner index).
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx
);

    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                idx   = IDW'((int'(ptr) + k) % N);
            end
        end
        if (en && found) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_add_sched_core.sv
// rtl/fp_add_sched_core.sv - combinational FP32 adder core
// Purpose: sum = a + b, round to nearest even; subnormal inputs and
//          results flush to zero, overflow saturates to infinity.
// Ports: a, b (FP32 operands), sum (FP32 result).
module fp32_add_core
    import fp_sched_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output fp32_t sum
);

    fp32_t       x, y;
    logic [23:0] mx, my;
    logic [7:0]  d;
    logic [26:0] my_ext, my_sh;
    logic        sticky;
    logic [27:0] s;
    logic [4:0]  pos, lsh;
    logic [26:0] n;
    logic [9:0]  e, e_out;
    logic        rnd_up;
    logic [24:0] r;

    always_comb begin
        // Larger magnitude first so the mantissa difference never goes negative.
        if (b[30:0] > a[30:0]) begin
            x = b;
            y = a;
        end else begin
            x = a;
            y = b;
        end
        mx = (x[30:23] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
        my = (y[30:23] == 8'd0) ? 24'd0 : {1'b1, y[22:0]};
        d  = x[30:23] - y[30:23];

        // Three extra low bits carry guard, round and sticky through alignment.
        my_ext = {my, 3'b000};
        if (d > 8'd26) begin
            my_sh  = '0;
            sticky = |my;
        end else begin
            my_sh  = my_ext >> d;
            sticky = |(my_ext & ((27'd1 << d) - 27'd1));
        end
        my_sh[0] = my_sh[0] | sticky;

        if (x[FP_SIGN] == y[FP_SIGN]) begin
            s = {1'b0, mx, 3'b000} + {1'b0, my_sh};
        end else begin
            s = {1'b0, mx, 3'b000} - {1'b0, my_sh};
        end

        e   = {2'b00, x[30:23]};
        pos = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (s[i]) begin
                pos = 5'(i);
            end
        end
        lsh = 5'd26 - pos;
        if (s[27]) begin
            n = {s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            n = s[26:0] << lsh;
            e = e - {5'd0, lsh};
        end

        rnd_up = n[2] & (n[1] | n[0] | n[3]);
        r      = {1'b0, n[26:3]} + {24'd0, rnd_up};
        e_out  = e + {9'd0, r[24]};

        if (x[30:23] == 8'hFF) begin
            sum = (y[30:23] == 8'hFF && x[FP_SIGN] != y[FP_SIGN]) ? 32'h7FC0_0000 : x;
        end else if (s == 28'd0) begin
            sum = {x[FP_SIGN] & y[FP_SIGN], 31'd0};
        end else if (e_out[9] || e_out == 10'd0) begin
            sum = {x[FP_SIGN], 31'd0};
        end else if (e_out >= 10'd255) begin
            sum = {x[FP_SIGN], 8'hFF, 23'd0};
        end else begin
            sum = {x[FP_SIGN], e_out[7:0], r[24] ? r[23:1] : r[22:0]};
        end
    end

endmodule

// File: rtl/fp_add_sched.sv
// rtl/fp_add_sched.sv - round-robin scheduler sharing one FP32 add/sub core
// Purpose: N requesters share one adder through issue (S1) and result (S2) stages.
// Ports: clk, reset (sync, active high); req_valid/req_ready/req_a/req_b/req_op
//        per requester; res_valid/res_ready/res_data/res_id result channel; busy.
module fp_add_sched
    import fp_sched_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = id_width(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [N*FP_W-1:0] req_a,
    input  logic [N*FP_W-1:0] req_b,
    input  logic [N-1:0]      req_op,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [FP_W-1:0]   res_data,
    output logic [IDW-1:0]    res_id,
    output logic              busy
);

    logic           s1_valid_q, s1_valid_d;
    fp32_t          s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;
    logic           res_valid_q, res_valid_d;
    fp32_t          res_data_q, res_data_d;
    logic [IDW-1:0] res_id_q, res_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    logic           advance, can_accept, accept;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] win_idx;
    fp32_t          win_a, win_b, core_sum;

    assign advance    = !res_valid_q || res_ready;
    assign can_accept = !s1_valid_q || advance;

    rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .en  (can_accept && !reset),
        .gnt (gnt),
        .idx (win_idx)
    );

    assign req_ready = gnt;
    assign accept    = |(req_valid & gnt);
    assign win_a     = req_a[int'(win_idx)*FP_W +: FP_W];
    // Subtraction is an add with B's sign flipped before it enters S1.
    assign win_b     = req_b[int'(win_idx)*FP_W +: FP_W] ^ {req_op[win_idx], 31'd0};

    fp32_add_core u_core (
        .a   (s1_a_q),
        .b   (s1_b_q),
        .sum (core_sum)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_id_d     = s1_id_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        rr_ptr_d    = rr_ptr_q;

        if (advance) begin
            res_valid_d = s1_valid_q;
            res_data_d  = core_sum;
            res_id_d    = s1_id_q;
        end

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = win_a;
            s1_b_d     = win_b;
            s1_id_d    = win_idx;
            rr_ptr_d   = (int'(win_idx) == N - 1) ? '0 : win_idx + IDW'(1);
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = s1_valid_q | res_valid_q;

endmodule

// File: tb/tb_fp_add_sched.sv
// tb/tb_fp_add_sched.sv - self-checking bench for fp_add_sched
module tb_fp_add_sched;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_a;
    logic [N*32-1:0]   req_b;
    logic [N-1:0]      req_op;
    logic              res_valid;
    logic              res_ready;
    logic [31:0]       res_data;
    logic [IDW-1:0]    res_id;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;

    logic [IDW+31:0] sb_q[$];
    logic [IDW+31:0] mon_exp;
    logic [31:0]     exp_tab[N];

    fp_add_sched #(.N(N), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Inputs change at negedge+1; the monitor samples the handshake at negedge+3.
    always begin
        @(negedge clk);
        #3;
        if (!reset && res_valid && res_ready) begin
            n_out++;
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL scoreboard_unexpected: got id=%0d data=%h, nothing outstanding", res_id, res_data);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({res_id, res_data} !== mon_exp)
                    $display("FAIL scoreboard_result: got id=%0d data=%h want id=%0d data=%h",
                             res_id, res_data, mon_exp[IDW+31:32], mon_exp[31:0]);
                else
                    n_pass++;
            end
        end
    end

    task automatic edge_drive();
        @(negedge clk);
        #1;
    endtask

    task automatic sample_accepts(output logic [N-1:0] acc);
        #1;
        acc = req_valid & req_ready;
        for (int i = 0; i < N; i++)
            if (acc[i]) sb_q.push_back({IDW'(i), exp_tab[i]});
    endtask

    task automatic load(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] expv);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[i]         = sub;
        exp_tab[i]        = expv;
    endtask

    task automatic load_table();
        load(0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000); // 1 + 2 = 3
        load(1, 32'h40A0_0000, 32'h4040_0000, 1'b1, 32'h4000_0000); // 5 - 3 = 2
        load(2, 32'h3FC0_0000, 32'h3E80_0000, 1'b0, 32'h3FE0_0000); // 1.5 + 0.25
        load(3, 32'h4000_0000, 32'h4100_0000, 1'b1, 32'hC0C0_0000); // 2 - 8 = -6
    endtask

    task automatic drain();
        int k;
        k = 0;
        do begin
            edge_drive();
            req_valid = '0;
            res_ready = 1'b1;
            k++;
        end while ((sb_q.size() != 0 || busy) && k < 40);
        n_checks++;
        if (sb_q.size() != 0 || busy)
            $display("FAIL drain_timeout: got outstanding=%0d busy=%b want 0 and 0", sb_q.size(), busy);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        logic [N-1:0] acc;
        load_table();
        reset     = 1'b1;
        req_valid = '1;
        res_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            edge_drive();
            #1;
            n_checks++;
            if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready);
            else n_pass++;
            n_checks++;
            if (res_valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL reset_idle: got res_valid=%b busy=%b want 0 0", res_valid, busy);
            else n_pass++;
        end
        edge_drive();
        reset = 1'b0;
        sample_accepts(acc);
        n_checks++;
        if (req_ready !== 4'b0001) $display("FAIL reset_first_grant: got %b want 0001", req_ready);
        else n_pass++;
        drain();
    endtask

    task automatic test_single_op(input string name, input int i, input logic [31:0] a,
                                  input logic [31:0] b, input logic sub, input logic [31:0] expv);
        logic [N-1:0] acc;
        logic [N-1:0] want;
        load(i, a, b, sub, expv);
        want    = '0;
        want[i] = 1'b1;
        edge_drive();
        req_valid = want;
        res_ready = 1'b1;
        sample_accepts(acc);
        n_checks++;
        if (acc !== want) $display("FAIL %s_accept: got %b want %b", name, acc, want);
        else n_pass++;
        edge_drive();
        req_valid = '0;
        #1;
        n_checks++;
        if (res_valid !== 1'b0) $display("FAIL %s_latency_t1: got res_valid=%b want 0", name, res_valid);
        else n_pass++;
        edge_drive();
        #1;
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== expv || res_id !== IDW'(i))
            $display("FAIL %s_result_t2: got v=%b data=%h id=%0d want v=1 data=%h id=%0d",
                     name, res_valid, res_data, res_id, expv, i);
        else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] acc;
        logic [N-1:0] want;
        edge_drive();
        reset = 1'b1;
        edge_drive();
        reset = 1'b0;
        load_table();
        for (int k = 0; k < 6; k++) begin
            edge_drive();
            req_valid = '1;
            res_ready = 1'b1;
            sample_accepts(acc);
            want = '0;
            want[k % N] = 1'b1;
            n_checks++;
            if (acc !== want) $display("FAIL b2b_grant_%0d: got %b want %b", k, acc, want);
            else n_pass++;
        end
        drain();
    endtask

    task automatic test_rounding();
        logic [N-1:0] acc;
        load(1, 32'h3F80_0000, 32'h3380_0001, 1'b0, 32'h3F80_0001); // above half ulp: round up
        load(3, 32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000); // exact tie: stay even
        edge_drive();
        req_valid = 4'b1010;
        res_ready = 1'b1;
        sample_accepts(acc);
        n_checks++;
        if (acc !== 4'b1000) $display("FAIL round_grant_first: got %b want 1000", acc);
        else n_pass++;
        edge_drive();
        req_valid = 4'b0010;
        sample_accepts(acc);
        n_checks++;
        if (acc !== 4'b0010) $display("FAIL round_grant_second: got %b want 0010", acc);
        else n_pass++;
        drain();
    endtask

    task automatic test_stall();
        logic [N-1:0] acc;
        int           total;
        int           out_before;
        load_table();
        total      = 0;
        out_before = n_out;
        for (int k = 0; k < 6; k++) begin
            edge_drive();
            req_valid = 4'b0011;
            res_ready = 1'b0;
            sample_accepts(acc);
            total += $countones(acc);
            if (k == 2) begin
                n_checks++;
                if (res_valid !== 1'b1 || res_data !== 32'h4040_0000)
                    $display("FAIL stall_first_result: got v=%b data=%h want v=1 data=40400000", res_valid, res_data);
                else n_pass++;
            end
        end
        n_checks++;
        if (req_ready !== 4'b0000) $display("FAIL stall_ready_low: got %b want 0000", req_ready);
        else n_pass++;
        n_checks++;
        if (res_data !== 32'h4040_0000 || res_id !== 2'd0)
            $display("FAIL stall_data_stable: got data=%h id=%0d want 40400000 id=0", res_data, res_id);
        else n_pass++;
        n_checks++;
        if (total != 2) $display("FAIL stall_accepts: got %0d want 2", total);
        else n_pass++;
        drain();
        n_checks++;
        if (n_out - out_before != 2) $display("FAIL stall_drain_count: got %0d want 2", n_out - out_before);
        else n_pass++;
    endtask

    task automatic test_reset_flush();
        logic [N-1:0] acc;
        int           out_before;
        res_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            edge_drive();
            req_valid = 4'b0100;
            res_ready = 1'b0;
            sample_accepts(acc);
        end
        edge_drive();
        req_valid = '0;
        #1;
        n_checks++;
        if (res_valid !== 1'b1 || busy !== 1'b1)
            $display("FAIL flush_full_before: got res_valid=%b busy=%b want 1 1", res_valid, busy);
        else n_pass++;
        edge_drive();
        reset = 1'b1;
        sb_q.delete();
        edge_drive();
        reset = 1'b0;
        #1;
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL flush_after_reset: got res_valid=%b busy=%b want 0 0", res_valid, busy);
        else n_pass++;
        out_before = n_out;
        res_ready  = 1'b1;
        repeat (6) edge_drive();
        n_checks++;
        if (n_out != out_before) $display("FAIL flush_stale_result: got %0d results want 0", n_out - out_before);
        else n_pass++;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        res_ready = 1'b1;
        test_reset();
        test_single_op("add_req0", 0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
        test_single_op("sub_req2", 2, 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000);
        test_back_to_back();
        test_rounding();
        test_stall();
        test_reset_flush();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
